// File: rtl/mod_stim_gen.sv
// mod_stim_gen: modulation stimulus generator for the DDS/DAC path.
// Drives amplitude, frequency and phase control words for CW/AM/FM/ASK/FSK/PSK.
// Digital types are keyed by a PRBS7 stream (x^7+x^6+1, seed 7F); analog
// types follow an 8-bit triangle that steps once per symbol.
// Optional build macro MOD_STIM_TRIG_OUT_EN enables meas_trigger/judge_trigger;
// without it both outputs are tied low and the symbol counter is not built.
//
// state | meaning
// IDLE  | outputs at reset values, waiting for a valid start
// RUN   | generating the latched type, one modulation step per SYM_DIV clocks
module mod_stim_gen #(
  parameter int                AMP_W      = 14,
  parameter int                FREQ_W     = 32,
  parameter int                PHASE_W    = 12,
  parameter int                SYM_DIV    = 1000,
  parameter logic [FREQ_W-1:0] CARRIER_FW = 32'h0147_AE14,
  parameter logic [FREQ_W-1:0] FSK_DEV    = 32'h0010_0000,
  parameter int                FM_SHIFT   = 12,
  parameter int                AM_SHIFT   = 4,
  parameter int                JUDGE_SYMS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         type_in,
  output logic [AMP_W-1:0]   amp_word,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [PHASE_W-1:0] phase_word,
  output logic               data_bit,
  output logic               sym_strobe,
  output logic               busy,
  output logic [2:0]         type_out,
  output logic               type_err,
  output logic               meas_trigger,
  output logic               judge_trigger
);

  localparam logic [2:0] T_CW  = 3'b000;
  localparam logic [2:0] T_AM  = 3'b001;
  localparam logic [2:0] T_FM  = 3'b010;
  localparam logic [2:0] T_NA  = 3'b100;
  localparam logic [2:0] T_ASK = 3'b101;
  localparam logic [2:0] T_FSK = 3'b110;
  localparam logic [2:0] T_PSK = 3'b111;

  localparam int                 TICK_W     = $clog2(SYM_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SYM_DIV - 1);
  localparam logic signed [31:0] AMP_MID    = 32'sd1 <<< (AMP_W - 1);
  localparam logic signed [31:0] AMP_MAX    = (32'sd1 <<< AMP_W) - 32'sd1;
  localparam logic [PHASE_W-1:0] PHASE_HALF = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [6:0]         LFSR_SEED  = 7'h7F;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [7:0]        tri_q;
  logic              tri_down;
  logic [6:0]        lfsr;

  logic              type_ok;
  logic              go_idle;
  logic              sym_end;
  logic [6:0]        lfsr_adv;
  logic [7:0]        tri_nx;
  logic              down_nx;
  logic              data_nx;
  logic signed [8:0] tri_s;
  logic signed [31:0] am_s;
  logic [FREQ_W-1:0] fm_dev;
  logic [AMP_W-1:0]  amp_nx;
  logic [FREQ_W-1:0] freq_nx;
  logic [PHASE_W-1:0] phase_nx;

  // Decode of start/stop and the per-symbol advance of LFSR and triangle
  always_comb begin
    type_ok  = (type_in != T_NA) && (type_in != 3'b011);
    go_idle  = stop || (start && !type_ok);
    sym_end  = (state == S_RUN) && (tick == TICK_LAST);
    lfsr_adv = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    tri_nx   = tri_q;
    down_nx  = tri_down;
    data_nx  = data_bit;
    if (sym_end) begin
      data_nx = lfsr_adv[0];
      // Each end value is held for one extra step while the direction flips.
      if (!tri_down) begin
        if (tri_q == 8'hFF) down_nx = 1'b1;
        else                tri_nx  = tri_q + 8'd1;
      end else begin
        if (tri_q == 8'h00) down_nx = 1'b0;
        else                tri_nx  = tri_q - 8'd1;
      end
    end
  end

  // Control words from the triangle/data values that will be current next
  // cycle, so the words change together with sym_strobe
  always_comb begin
    amp_nx   = '1;
    freq_nx  = CARRIER_FW;
    phase_nx = '0;
    tri_s    = $signed({1'b0, tri_nx}) - 9'sd128;
    am_s     = AMP_MID + (32'(tri_s) <<< AM_SHIFT);
    fm_dev   = FREQ_W'(tri_s) << FM_SHIFT;
    case (type_out)
      T_AM: begin
        if (am_s < 0)            amp_nx = '0;
        else if (am_s > AMP_MAX) amp_nx = '1;
        else                     amp_nx = am_s[AMP_W-1:0];
      end
      T_FM:  freq_nx  = CARRIER_FW + fm_dev;
      T_ASK: amp_nx   = data_nx ? '1 : '0;
      T_FSK: freq_nx  = data_nx ? (CARRIER_FW + FSK_DEV) : (CARRIER_FW - FSK_DEV);
      T_PSK: phase_nx = data_nx ? PHASE_HALF : '0;
      default: ;
    endcase
  end

  // Main FSM with registered outputs; stop beats start, LFSR survives stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tick       <= '0;
      tri_q      <= '0;
      tri_down   <= 1'b0;
      lfsr       <= LFSR_SEED;
      amp_word   <= '0;
      freq_word  <= '0;
      phase_word <= '0;
      data_bit   <= 1'b0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      type_out   <= T_NA;
      type_err   <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      type_err   <= 1'b0;
      if (go_idle) begin
        state      <= S_IDLE;
        tick       <= '0;
        tri_q      <= '0;
        tri_down   <= 1'b0;
        amp_word   <= '0;
        freq_word  <= '0;
        phase_word <= '0;
        data_bit   <= 1'b0;
        busy       <= 1'b0;
        type_out   <= T_NA;
        type_err   <= !stop;
      end else if (start) begin
        state    <= S_RUN;
        busy     <= 1'b1;
        type_out <= type_in;
        lfsr     <= LFSR_SEED;
        tick     <= '0;
        tri_q    <= '0;
        tri_down <= 1'b0;
        data_bit <= 1'b0;
      end else if (state == S_RUN) begin
        tick       <= sym_end ? '0 : tick + TICK_W'(1);
        tri_q      <= tri_nx;
        tri_down   <= down_nx;
        data_bit   <= data_nx;
        amp_word   <= amp_nx;
        freq_word  <= freq_nx;
        phase_word <= phase_nx;
        if (sym_end) begin
          sym_strobe <= 1'b1;
          lfsr       <= lfsr_adv;
        end
      end
    end
  end

`ifdef MOD_STIM_TRIG_OUT_EN
  localparam int SCNT_W = $clog2(JUDGE_SYMS + 1);

  logic [SCNT_W-1:0] sym_cnt;

  // Discriminator triggers: measure on every RUN entry, judge once per run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt       <= '0;
      meas_trigger  <= 1'b0;
      judge_trigger <= 1'b0;
    end else begin
      meas_trigger  <= 1'b0;
      judge_trigger <= 1'b0;
      if (go_idle) begin
        sym_cnt <= '0;
      end else if (start) begin
        sym_cnt      <= '0;
        meas_trigger <= 1'b1;
      end else if (sym_end && (sym_cnt < SCNT_W'(JUDGE_SYMS))) begin
        sym_cnt <= sym_cnt + SCNT_W'(1);
        if (sym_cnt == SCNT_W'(JUDGE_SYMS - 1)) judge_trigger <= 1'b1;
      end
    end
  end
`else
  assign meas_trigger  = 1'b0;
  assign judge_trigger = 1'b0;
`endif

endmodule

// File: tb/tb_mod_stim_gen.sv
// tb_mod_stim_gen: directed stimulus for mod_stim_gen with a per-cycle model
// compare (symbol index, triangle and PRBS derived arithmetically) plus
// hand-computed literal expectations at chosen cycles.
module tb_mod_stim_gen;
  localparam int          SD   = 4;
  localparam int          JS   = 4;
  localparam int          MAXK = 1200;
  localparam logic [31:0] CFW  = 32'h0147_AE14;
  localparam logic [31:0] DEV  = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  type_in = 3'b000;
  logic [13:0] amp_word;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic        data_bit, sym_strobe, busy, type_err, meas_trigger, judge_trigger;
  logic [2:0]  type_out;

  mod_stim_gen #(
    .AMP_W(14), .FREQ_W(32), .PHASE_W(12), .SYM_DIV(SD),
    .CARRIER_FW(CFW), .FSK_DEV(DEV), .FM_SHIFT(12), .AM_SHIFT(4), .JUDGE_SYMS(JS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .type_in(type_in),
    .amp_word(amp_word), .freq_word(freq_word), .phase_word(phase_word),
    .data_bit(data_bit), .sym_strobe(sym_strobe), .busy(busy),
    .type_out(type_out), .type_err(type_err),
    .meas_trigger(meas_trigger), .judge_trigger(judge_trigger)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit prbs [0:MAXK];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // PRBS bit b_k: b_k = b_(k-6) ^ b_(k-7), with b_-6..b_0 all ones (seed 7F)
  task automatic fill_prbs();
    bit s [0:MAXK+6];
    for (int j = 0; j <= MAXK + 6; j++) s[j] = (j < 7) ? 1'b1 : (s[j-6] ^ s[j-7]);
    for (int k = 0; k <= MAXK; k++) prbs[k] = s[k+6];
  endtask

  function automatic int tri_of(input int k);
    int p;
    p = k % 512;
    return (p <= 255) ? p : 511 - p;
  endfunction

  function automatic bit dat_of(input int k);
    return (k == 0) ? 1'b0 : prbs[k];
  endfunction

  function automatic logic [13:0] exp_amp(input logic [2:0] t, input int k);
    int v;
    case (t)
      3'b001: begin
        v = 8192 + (tri_of(k) - 128) * 16;
        if (v < 0) v = 0;
        if (v > 16383) v = 16383;
      end
      3'b101: v = dat_of(k) ? 16383 : 0;
      default: v = 16383;
    endcase
    return 14'(v);
  endfunction

  function automatic logic [31:0] exp_freq(input logic [2:0] t, input int k);
    int d;
    case (t)
      3'b010: begin
        d = (tri_of(k) - 128) * 4096;
        return CFW + 32'(d);
      end
      3'b110: return dat_of(k) ? CFW + DEV : CFW - DEV;
      default: return CFW;
    endcase
  endfunction

  function automatic logic [11:0] exp_phase(input logic [2:0] t, input int k);
    return (t == 3'b111 && dat_of(k)) ? 12'd2048 : 12'd0;
  endfunction

  // Model state: running flag, cycles since RUN entry, latched type
  bit         m_run = 1'b0;
  bit         m_err = 1'b0;
  int         m_c = 0;
  logic [2:0] m_type = 3'b100;

  always @(posedge clk) begin
    if (rst_n) begin
      m_err = 1'b0;
      if (stop) m_run = 1'b0;
      else if (start) begin
        if (type_in inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111}) begin
          m_run = 1'b1; m_c = 0; m_type = type_in;
        end else begin
          m_run = 1'b0; m_err = 1'b1;
        end
      end else if (m_run) m_c++;
    end
  end

  always @(negedge rst_n) begin
    m_run = 1'b0;
    m_err = 1'b0;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    int k;
    if (rst_n) begin
      chk("busy", busy, m_run);
      chk("type_out", type_out, m_run ? m_type : 3'b100);
      chk("type_err", type_err, m_err);
      if (!m_run) begin
        chk("idle_amp", amp_word, 0);
        chk("idle_freq", freq_word, 0);
        chk("idle_phase", phase_word, 0);
        chk("idle_data", data_bit, 0);
        chk("idle_strobe", sym_strobe, 0);
      end else begin
        k = m_c / SD;
        if (k > MAXK) k = MAXK;
        chk("sym_strobe", sym_strobe, (m_c > 0) && (m_c % SD == 0));
        chk("data_bit", data_bit, dat_of(k));
        if (m_c >= 1) begin
          chk("amp_word", amp_word, exp_amp(m_type, k));
          chk("freq_word", freq_word, exp_freq(m_type, k));
          chk("phase_word", phase_word, exp_phase(m_type, k));
        end
      end
`ifdef MOD_STIM_TRIG_OUT_EN
      chk("meas_trigger", meas_trigger, m_run && m_c == 0);
      chk("judge_trigger", judge_trigger, m_run && m_c == JS * SD);
`else
      chk("meas_trigger", meas_trigger, 0);
      chk("judge_trigger", judge_trigger, 0);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Returns 2 time units after the edge that samples start (RUN cycle 0)
  task automatic do_start(input logic [2:0] t);
    start = 1'b1;
    type_in = t;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    fill_prbs();
    cyc(2);
    chk("rst_amp", amp_word, 0);
    chk("rst_freq", freq_word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_type_out", type_out, 3'b100);
    rst_n = 1'b1;
    cyc(1);

    // CW
    do_start(3'b000);
    chk("cw_busy_c0", busy, 1);
    cyc(1);
    chk("cw_amp", amp_word, 14'd16383);
    chk("cw_freq", freq_word, 32'h0147_AE14);
    chk("cw_phase", phase_word, 0);
    cyc(3);
    chk("cw_strobe_c4", sym_strobe, 1);
    cyc(1);
    chk("cw_strobe_c5", sym_strobe, 0);
    cyc(15);

    // PSK (restart from RUN)
    do_start(3'b111);
    cyc(26);
    chk("psk_k6", phase_word, 12'd0);
    cyc(4);
    chk("psk_k7", phase_word, 12'd2048);
    chk("psk_k7_data", data_bit, 1);
    cyc(4 * 127);
    chk("psk_k134", phase_word, 12'd2048);
    cyc(400);

    // FSK
    do_start(3'b110);
    cyc(6);
    chk("fsk_k1", freq_word, 32'h0137_AE14);
    cyc(24);
    chk("fsk_k7", freq_word, 32'h0157_AE14);
    chk("fsk_amp", amp_word, 14'd16383);
    cyc(20);

    // FM
    do_start(3'b010);
    cyc(1);
    chk("fm_k0", freq_word, 32'h013F_AE14);
    cyc(4);
    chk("fm_k1", freq_word, 32'h013F_BE14);
    cyc(10);

    // AM across a full triangle period
    do_start(3'b001);
    cyc(2);
    chk("am_k0", amp_word, 14'd6144);
    cyc(1020);
    chk("am_k255", amp_word, 14'd10224);
    cyc(4);
    chk("am_k256", amp_word, 14'd10224);
    cyc(4 * 255);
    chk("am_k511", amp_word, 14'd6144);
    cyc(4);
    chk("am_k512", amp_word, 14'd6144);
    cyc(20);

    // ASK
    do_start(3'b101);
    cyc(30);
    chk("ask_k7", amp_word, 14'd16383);
    cyc(2);
    chk("ask_k8", amp_word, 14'd0);
    cyc(20);

    // stop
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_amp", amp_word, 0);
    chk("stop_type_out", type_out, 3'b100);
    cyc(3);

    // invalid codes from IDLE
    do_start(3'b100);
    chk("inv100_err", type_err, 1);
    chk("inv100_busy", busy, 0);
    chk("inv100_type_out", type_out, 3'b100);
    cyc(1);
    chk("inv100_err_clr", type_err, 0);
    do_start(3'b011);
    chk("inv011_err", type_err, 1);
    cyc(2);

    // start and stop together during RUN
    do_start(3'b000);
    cyc(5);
    start = 1'b1; stop = 1'b1; type_in = 3'b111;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_amp", amp_word, 0);
    chk("ss_freq", freq_word, 0);
    chk("ss_err", type_err, 0);
    cyc(2);

    // invalid restart during RUN
    do_start(3'b110);
    cyc(5);
    do_start(3'b100);
    chk("rinv_err", type_err, 1);
    chk("rinv_busy", busy, 0);
    chk("rinv_freq", freq_word, 0);
    cyc(2);

`ifdef MOD_STIM_TRIG_OUT_EN
    do_start(3'b101);
    chk("meas_c0", meas_trigger, 1);
    cyc(1);
    chk("meas_c1", meas_trigger, 0);
    cyc(15);
    chk("judge_c16", judge_trigger, 1);
    chk("judge_strobe", sym_strobe, 1);
    cyc(1);
    chk("judge_c17", judge_trigger, 0);
    cyc(20);
`endif

    // asynchronous reset mid-run
    do_start(3'b000);
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("arst_amp", amp_word, 0);
    chk("arst_freq", freq_word, 0);
    chk("arst_busy", busy, 0);
    chk("arst_type_out", type_out, 3'b100);
    chk("arst_strobe", sym_strobe, 0);
    chk("arst_trig", {meas_trigger, judge_trigger}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod_stim_gen.md
Name: mod_stim_gen

Overview:
- Modulation stimulus generator: the transmit-side counterpart of the signal-type discriminator.
- Takes a 3-bit signal-type code (CW/AM/FM/ASK/FSK/PSK) and drives the amplitude, frequency and phase control words of the DDS/DAC path.
- Digital types are keyed by a PRBS7 bit stream; analog types are driven by a triangle modulating waveform.
- Used for closed-loop self-test of the demodulation chain and for bench signal generation.

Parameters:
- AMP_W, 14, amplitude word width (unsigned)
- FREQ_W, 32, DDS frequency tuning word width
- PHASE_W, 12, phase offset word width
- SYM_DIV, 1000, clocks per symbol / modulation step (>=2)
- CARRIER_FW, 32'h0147_AE14, carrier tuning word
- FSK_DEV, 32'h0010_0000, FSK tuning-word deviation
- FM_SHIFT, 12, left shift applied to the signed triangle for FM
- AM_SHIFT, 4, left shift applied to the triangle for AM
- JUDGE_SYMS, 64, symbols from run start to judge pulse (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; latch type_in and start or restart generation
- stop  in  1  pulse; return to idle
- type_in  in  3  CW=000 AM=001 FM=010 ASK=101 FSK=110 PSK=111 NA=100
- amp_word  out  AMP_W  amplitude control
- freq_word  out  FREQ_W  DDS tuning word
- phase_word  out  PHASE_W  phase offset
- data_bit  out  1  current PRBS symbol
- sym_strobe  out  1  one-cycle pulse per symbol boundary
- busy  out  1  high in RUN
- type_out  out  3  currently generated type; NA when idle
- type_err  out  1  one-cycle pulse when start carries an invalid code
- meas_trigger  out  1  optional, see below
- judge_trigger  out  1  optional, see below

Behaviour:
- Reset (async, rst_n low): state IDLE; amp_word/freq_word/phase_word/data_bit/sym_strobe/busy/type_err = 0; type_out = NA; tick counter 0; triangle 0, direction up; LFSR = 7'h7F.
- States: IDLE, RUN.
- IDLE + start with type_in in {000,001,010,101,110,111}: latch type, reseed LFSR, clear tick counter and triangle; next cycle RUN, busy = 1.
- IDLE + start with any other code (100, 011): stay IDLE; type_err high for 1 cycle.
- RUN + start: restart as if from IDLE with the new code. An invalid code goes to IDLE and pulses type_err.
- stop in any state: IDLE next cycle; outputs cleared to reset values except the LFSR. start and stop in the same cycle: stop wins.
- Tick counter 0..SYM_DIV-1, wraps.
- At tick == SYM_DIV-1: sym_strobe = 1 in the following cycle; LFSR advances (x^7+x^6+1, data_bit = new LSB); triangle steps by 1.
- Triangle: 8-bit, counts 0->255->0, reverses direction at both ends; the 255 and 0 values are each held for one step.
- Output words registered. They update in the same cycle sym_strobe asserts; first values appear 1 cycle after entering RUN.
  - CW: amp = all ones; freq = CARRIER_FW; phase = 0.
  - AM: amp = (2^(AMP_W-1)) + ((tri - 128) <<< AM_SHIFT), signed, saturated to [0, 2^AMP_W-1]; freq = CARRIER_FW.
  - FM: freq = CARRIER_FW + sign-extended (tri - 128) << FM_SHIFT, wrap modulo 2^FREQ_W; amp = all ones.
  - ASK: amp = data_bit ? all ones : 0.
  - FSK: freq = CARRIER_FW +/- FSK_DEV per data_bit (1 = +), modulo 2^FREQ_W; amp = all ones.
  - PSK: phase = data_bit ? 2^(PHASE_W-1) : 0; amp = all ones; freq = CARRIER_FW.
- type_out = latched type while busy.

Optional Feature:
- MOD_STIM_TRIG_OUT_EN defined:
  - meas_trigger pulses 1 cycle on every RUN entry (including restart).
  - judge_trigger pulses 1 cycle coincident with the JUDGE_SYMS-th sym_strobe after entry, once per run.
  - Both drive the discriminator directly.
- Undefined: both ports tied 0, symbol counter not synthesized.

Test Plan:
- SYM_DIV=4, reset, start with type_in=000 -> RUN next cycle, amp=16383, freq=CARRIER_FW, phase=0, sym_strobe every 4 clocks.
- start with 111 -> phase_word follows PRBS7 from seed 7F, 0 or 2048 per symbol; the bit sequence repeats every 127 symbols.
- start with 110 -> freq alternates CARRIER_FW+/-32'h0010_0000 matching data_bit; amp constant.
- start with 001, 512 symbols -> amp triangle from 8192-2048 to 8192+2032, no saturation; direction reverses at tri 255 and 0.
- start with 100 -> type_err one pulse, busy stays 0, type_out=100; start and stop in the same cycle during RUN -> IDLE, outputs 0.
- MOD_STIM_TRIG_OUT_EN, JUDGE_SYMS=4 -> meas_trigger at RUN entry; judge_trigger with the 4th sym_strobe; rst_n low mid-run -> all outputs reset immediately.
